// File: rtl/nfault_arbiter_pkg.sv
// rtl/nfault_arbiter_pkg.sv - shared state encoding, default parameters and reset constants for nfault_arbiter
package nfault_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LATCH   = 2'd1,
        S_ASSERT  = 2'd2,
        S_RELEASE = 2'd3
    } nfault_state_t;

    localparam int DEF_NUM_SUBSYSTEMS   = 4;
    localparam int DEF_FAULT_CODE_WIDTH = 8;
    localparam int DEF_WATCHDOG_CYCLES  = 1_000_000;

    // Pointer value after reset: the highest index, so the first search starts at index 0.
    function automatic int last_grant_reset(input int num_subsystems);
        return num_subsystems - 1;
    endfunction

endpackage

// File: rtl/nfault_arbiter_if.sv
// rtl/nfault_arbiter_if.sv - fault request/code/acknowledge bundle between subsystems and nfault_arbiter
interface nfault_arbiter_if
    import nfault_arbiter_pkg::*;
#(
    parameter int NUM_SUBSYSTEMS   = DEF_NUM_SUBSYSTEMS,
    parameter int FAULT_CODE_WIDTH = DEF_FAULT_CODE_WIDTH
);

    logic [NUM_SUBSYSTEMS-1:0]                       fault_req;
    logic [NUM_SUBSYSTEMS-1:0][FAULT_CODE_WIDTH-1:0] fault_code;
    logic [NUM_SUBSYSTEMS-1:0]                       fault_ack;

    // Fault sources: raise requests with codes, receive acknowledges.
    modport master (
        output fault_req,
        output fault_code,
        input  fault_ack
    );

    // Arbiter: samples requests and codes, issues acknowledges.
    modport slave (
        input  fault_req,
        input  fault_code,
        output fault_ack
    );

endinterface

// File: rtl/nfault_arbiter_rr_arbiter.sv
// rtl/nfault_arbiter_rr_arbiter.sv - combinational round-robin pick starting one past the last grant
module rr_arbiter #(
    parameter int NUM_SUBSYSTEMS = 4,
    parameter int ID_W           = $clog2(NUM_SUBSYSTEMS)
) (
    input  logic [NUM_SUBSYSTEMS-1:0] req,
    input  logic [ID_W-1:0]           last_grant,
    output logic [ID_W-1:0]           grant_id,
    output logic                      any_req
);

    // Scan offsets from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        int idx;
        idx      = 0;
        grant_id = '0;
        any_req  = |req;
        for (int off = NUM_SUBSYSTEMS; off >= 1; off--) begin
            idx = (int'(last_grant) + off) % NUM_SUBSYSTEMS;
            if (req[idx]) begin
                grant_id = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/nfault_arbiter.sv
// rtl/nfault_arbiter.sv - shares the nFault line among subsystems, round-robin grant and host clear; optional watchdog via NFAULT_WATCHDOG_EN
module nfault_arbiter
    import nfault_arbiter_pkg::*;
#(
    parameter int NUM_SUBSYSTEMS   = DEF_NUM_SUBSYSTEMS,
    parameter int FAULT_CODE_WIDTH = DEF_FAULT_CODE_WIDTH,
    parameter int WATCHDOG_CYCLES  = DEF_WATCHDOG_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    nfault_arbiter_if.slave               fault_bus,
    input  logic                          clear_fault,
    output logic                          nFault_drive_low,
    output logic [$clog2(NUM_SUBSYSTEMS)-1:0] active_fault_id,
    output logic [FAULT_CODE_WIDTH-1:0]   active_fault_code,
    output logic                          fault_active,
    output logic                          fault_escalate
);

    localparam int ID_W = $clog2(NUM_SUBSYSTEMS);
    localparam logic [ID_W-1:0] LAST_GRANT_RST = ID_W'(last_grant_reset(NUM_SUBSYSTEMS));

    nfault_state_t   state;
    nfault_state_t   next_state;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] rr_grant;
    logic            any_req;

    rr_arbiter #(
        .NUM_SUBSYSTEMS (NUM_SUBSYSTEMS),
        .ID_W           (ID_W)
    ) u_rr_arbiter (
        .req        (fault_bus.fault_req),
        .last_grant (last_grant),
        .grant_id   (rr_grant),
        .any_req    (any_req)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: grant, acknowledge, hold nFault until host clear, then one release cycle.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (any_req) next_state = S_LATCH;
            S_LATCH:   next_state = S_ASSERT;
            S_ASSERT:  if (clear_fault) next_state = S_RELEASE;
            S_RELEASE: next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        fault_bus.fault_ack = '0;
        nFault_drive_low    = 1'b0;
        fault_active        = 1'b0;
        case (state)
            S_LATCH:  fault_bus.fault_ack[grant_id] = 1'b1;
            S_ASSERT: begin
                nFault_drive_low = 1'b1;
                fault_active     = 1'b1;
            end
            default: ;
        endcase
    end

    // Grant pointer, round-robin history and host-visible latched fault identity/code.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_id          <= '0;
            last_grant        <= LAST_GRANT_RST;
            active_fault_id   <= '0;
            active_fault_code <= '0;
        end else begin
            case (state)
                S_IDLE: if (any_req) grant_id <= rr_grant;
                S_LATCH: begin
                    active_fault_id   <= grant_id;
                    active_fault_code <= fault_bus.fault_code[grant_id];
                end
                S_RELEASE: last_grant <= grant_id;
                default: ;
            endcase
        end
    end

`ifdef NFAULT_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WATCHDOG_CYCLES);

    logic [WD_W-1:0] wd_count;
    logic            wd_escalate;

    // Count cycles spent in S_ASSERT; escalate once the limit is reached and keep it until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_count    <= '0;
            wd_escalate <= 1'b0;
        end else begin
            if (state == S_LATCH) begin
                wd_count <= '0;
            end else if (state == S_ASSERT && wd_count != WD_LIMIT) begin
                wd_count <= wd_count + 1'b1;
                if (wd_count + 1'b1 == WD_LIMIT) begin
                    wd_escalate <= 1'b1;
                end
            end
        end
    end

    assign fault_escalate = wd_escalate;
`else
    assign fault_escalate = 1'b0;
`endif

endmodule

// File: tb/tb_nfault_arbiter.sv
// tb/tb_nfault_arbiter.sv - randomized self-checking bench for nfault_arbiter against a transaction-level model
module tb_nfault_arbiter;
    import nfault_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int WD = 10;
`ifdef NFAULT_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         clear_fault = 1'b0;
    logic         nFault_drive_low;
    logic [1:0]   active_fault_id;
    logic [W-1:0] active_fault_code;
    logic         fault_active;
    logic         fault_escalate;

    nfault_arbiter_if #(.NUM_SUBSYSTEMS(N), .FAULT_CODE_WIDTH(W)) fbus ();

    nfault_arbiter #(
        .NUM_SUBSYSTEMS   (N),
        .FAULT_CODE_WIDTH (W),
        .WATCHDOG_CYCLES  (WD)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .fault_bus         (fbus.slave),
        .clear_fault       (clear_fault),
        .nFault_drive_low  (nFault_drive_low),
        .active_fault_id   (active_fault_id),
        .active_fault_code (active_fault_code),
        .fault_active      (fault_active),
        .fault_escalate    (fault_escalate)
    );

    always #5 clk = ~clk;

    int           errors = 0;
    int           checks = 0;
    logic [N-1:0] req_m = '0;
    logic [W-1:0] code_m [N];
    int           last_m = N - 1;
    bit           esc_m = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bus();
        fbus.fault_req = req_m;
        for (int i = 0; i < N; i++) fbus.fault_code[i] = code_m[i];
    endtask

    // Requesters newly raising a fault present a fresh random code; held ones keep theirs.
    task automatic add_reqs(input logic [N-1:0] add);
        for (int i = 0; i < N; i++) begin
            if (add[i] && !req_m[i]) begin
                req_m[i]  = 1'b1;
                code_m[i] = W'($urandom);
            end
        end
        drive_bus();
    endtask

    // Round-robin rule: first requester found walking upward from one past the previous grant.
    function automatic int winner(input logic [N-1:0] r, input int last);
        for (int off = 1; off <= N; off++) begin
            if (r[(last + off) % N]) return (last + off) % N;
        end
        return -1;
    endfunction

    // One full fault: entered in S_IDLE with requests already driven; leaves in S_IDLE.
    task automatic episode(input int hold, input bit keep);
        int w;
        w = winner(req_m, last_m);
        step();
        check("ack_onehot", 32'(fbus.fault_ack), 32'(1) << w);
        check("latch_nfault", 32'(nFault_drive_low), 0);
        step();
        check("ack_width", 32'(fbus.fault_ack), 0);
        check("assert_nfault", 32'(nFault_drive_low), 1);
        check("assert_active", 32'(fault_active), 1);
        check("active_id", 32'(active_fault_id), w);
        check("active_code", 32'(active_fault_code), 32'(code_m[w]));
        for (int h = 0; h < hold; h++) begin
            step();
            check("hold_nfault", 32'(nFault_drive_low), 1);
        end
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;
        check("release_nfault", 32'(nFault_drive_low), 0);
        check("release_active", 32'(fault_active), 0);
        check("held_id", 32'(active_fault_id), w);
        check("held_code", 32'(active_fault_code), 32'(code_m[w]));
        last_m = w;
        if (!keep) req_m[w] = 1'b0;
        drive_bus();
        step();
        check("gap_nfault", 32'(nFault_drive_low), 0);
        check("gap_ack", 32'(fbus.fault_ack), 0);
        check("escalate", 32'(fault_escalate), 32'(esc_m));
    endtask

    initial begin
        for (int i = 0; i < N; i++) code_m[i] = '0;
        drive_bus();
        repeat (3) @(posedge clk);
        #1;
        check("in_reset_outs", {fbus.fault_ack, nFault_drive_low, active_fault_id,
                                active_fault_code, fault_active, fault_escalate}, 0);
        reset = 1'b1;

        // Idle after reset: every output stays low.
        for (int c = 0; c < 20; c++) begin
            step();
            check("idle_outs", {fbus.fault_ack, nFault_drive_low, active_fault_id,
                                active_fault_code, fault_active, fault_escalate}, 0);
        end

        // All four requesting and held: grants rotate 0,1,2,3,0.
        add_reqs(4'b1111);
        for (int e = 0; e < 5; e++) episode(e % 3, 1'b1);
        req_m = '0;
        drive_bus();
        step();

        // Single request with a known code.
        add_reqs(4'b0100);
        code_m[2] = 8'hA5;
        drive_bus();
        episode(1, 1'b0);

        // Clear in S_IDLE is not remembered: nFault must stay low until a clear in S_ASSERT.
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;
        check("idle_clear_nfault", 32'(nFault_drive_low), 0);
        add_reqs(4'b0001);
        episode(6, 1'b0);

        // Reset in S_ASSERT releases nFault and clears the latches; the held request is re-granted.
        add_reqs(4'b1000);
        step();
        step();
        check("pre_reset_nfault", 32'(nFault_drive_low), 1);
        reset = 1'b0;
        #1;
        check("async_reset_outs", {fbus.fault_ack, nFault_drive_low, active_fault_id,
                                   active_fault_code, fault_active}, 0);
        step();
        reset = 1'b1;
        last_m = N - 1;
        esc_m  = 1'b0;
        episode(2, 1'b0);

        // Long S_ASSERT: escalation after WD cycles only when the watchdog is built in.
        add_reqs(4'b0001);
        step();
        check("wd_ack", 32'(fbus.fault_ack), 1);
        step();
        check("wd_first_cycle", 32'(fault_escalate), 0);
        for (int i = 2; i <= WD + 2; i++) begin
            step();
            check("wd_escalate", 32'(fault_escalate), 32'(WD_ON && i >= WD + 1));
        end
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;
        esc_m = WD_ON;
        check("wd_after_clear", 32'(fault_escalate), 32'(esc_m));
        last_m = 0;
        req_m[0] = 1'b0;
        drive_bus();
        step();

        // Randomized traffic against the round-robin model.
        for (int e = 0; e < 40; e++) begin
            if (req_m == '0) begin
                int idle;
                idle = $urandom_range(0, 3);
                for (int c = 0; c < idle; c++) begin
                    step();
                    check("rand_idle_nfault", 32'(nFault_drive_low), 0);
                end
                add_reqs(N'($urandom_range(1, (1 << N) - 1)));
            end else if ($urandom_range(0, 1) == 1) begin
                add_reqs(N'($urandom) & N'($urandom));
            end
            episode($urandom_range(0, 4), $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
